arb_requester: RTL and testbench

//   Client-side agent for the two-way req/gnt arbiter; one instance per requestor.

---
 rtl/arb_requester.sv | 177 +++++++++++++++++
 tb/tb_arb_requester.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arb_requester                                                |
// | Description : Client-side agent for a two-way req/gnt arbiter. Accepts a   |
// |               burst command, requests the bus, moves cmd_len+1 beats from  |
// |               a local source while the grant is held, then releases.       |
// | Options     : `define REQ_TIMEOUT_EN adds a grant-wait timeout (TIMEOUT    |
// |               cycles in REQ without gnt aborts with err_code 10).          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module arb_requester #(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4
`ifdef REQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_cmd_valid,
  input  logic [LEN_W-1:0]  i_cmd_len,
  output logic              o_cmd_ready,
  output logic              o_req,
  input  logic              i_gnt,
  output logic              o_src_rd,
  input  logic [DATA_W-1:0] i_src_data,
  output logic              o_bus_valid,
  output logic [DATA_W-1:0] o_bus_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [1:0]        o_err_code
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_REL  = 2'd3
  } state_t;

  localparam logic [1:0] c_ERR_GNT_LOST = 2'b01;
  localparam logic [1:0] c_ERR_TIMEOUT  = 2'b10;

  state_t              r_state;
  state_t              w_state_next;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_cnt;
  logic                r_bus_valid;
  logic [DATA_W-1:0]   r_bus_data;
  logic                r_done;
  logic                r_err;
  logic [1:0]          r_err_code;

  logic                w_accept;
  logic                w_beat;
  logic                w_last;
  logic                w_lost;
  logic                w_timeout;

  assign w_accept = i_cmd_valid && (r_state == S_IDLE);
  // A beat moves in every XFER cycle that still holds the grant.
  assign w_beat   = (r_state == S_XFER) && i_gnt;
  assign w_lost   = (r_state == S_XFER) && !i_gnt;
  // Compare before increment so a full 2**LEN_W burst never wraps early.
  assign w_last   = (r_cnt == r_len);

`ifdef REQ_TIMEOUT_EN
  localparam int               WAIT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] r_wait;

  // Count grant-less REQ cycles; restarted whenever a new command enters REQ.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait <= '0;
    end else if (w_accept) begin
      r_wait <= '0;
    end else if ((r_state == S_REQ) && !i_gnt) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  // A grant arriving in the final wait cycle takes priority over the timeout.
  assign w_timeout = (r_state == S_REQ) && !i_gnt && (r_wait == c_WAIT_LAST);
`else
  // Without the timeout option REQ waits for the grant indefinitely.
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (i_gnt) begin
          w_state_next = S_XFER;
        end else if (w_timeout) begin
          w_state_next = S_REL;
        end
      end
      S_XFER: begin
        if (!i_gnt || w_last) begin
          w_state_next = S_REL;
        end
      end
      S_REL: begin
        // Leave only once the arbiter has dropped the grant.
        if (!i_gnt) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Command capture, beat counter, bus beat register and status pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_len       <= '0;
      r_cnt       <= '0;
      r_bus_valid <= 1'b0;
      r_bus_data  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      r_bus_valid <= w_beat;
      r_done      <= w_beat && w_last;
      r_err       <= w_lost || w_timeout;
      if (w_beat) begin
        r_bus_data <= i_src_data;
      end
      if (w_lost) begin
        r_err_code <= c_ERR_GNT_LOST;
      end else if (w_timeout) begin
        r_err_code <= c_ERR_TIMEOUT;
      end
      if (w_accept) begin
        r_len <= i_cmd_len;
        r_cnt <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_req       = (r_state == S_REQ) || (r_state == S_XFER);
  assign o_src_rd    = w_beat;
  assign o_bus_valid = r_bus_valid;
  assign o_bus_data  = r_bus_data;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_arb_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_arb_requester                                             |
// | Description : Self-checking bench for arb_requester with a registered      |
// |               1-cycle-latency arbiter model, a FIFO-like source model and  |
// |               a beat scoreboard. Honours `define REQ_TIMEOUT_EN.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_arb_requester;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;
`ifdef REQ_TIMEOUT_EN
  localparam int TIMEOUT = 16;
`endif

  logic              clock     = 1'b0;
  logic              reset     = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [LEN_W-1:0]  cmd_len   = '0;
  logic              cmd_ready;
  logic              req;
  logic              gnt       = 1'b0;
  logic              src_rd;
  logic [DATA_W-1:0] src_data;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  arb_requester #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
`ifdef REQ_TIMEOUT_EN
    ,
    .TIMEOUT(TIMEOUT)
`endif
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .i_cmd_valid(cmd_valid),
    .i_cmd_len  (cmd_len),
    .o_cmd_ready(cmd_ready),
    .o_req      (req),
    .i_gnt      (gnt),
    .o_src_rd   (src_rd),
    .i_src_data (src_data),
    .o_bus_valid(bus_valid),
    .o_bus_data (bus_data),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_err_code (err_code)
  );

  always #5 clock = ~clock;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- source and arbiter models ----------------
  logic [DATA_W-1:0] src_mem [256];
  int  src_ptr  = 0;          // total words popped so far
  bit  arb_on   = 1'b1;       // arbiter grants at all
  bit  limit_en = 1'b0;       // arbiter withdraws grant once src_ptr reaches kill_at
  int  kill_at  = 0;

  assign src_data = src_mem[src_ptr[7:0]];

  always @(posedge clock) begin
    if (src_rd) src_ptr <= src_ptr + 1;
  end

  // Registered arbiter: grant follows request one cycle later.
  always @(posedge clock) begin
    if (reset) gnt <= 1'b0;
    else gnt <= arb_on && req && !(limit_en && ((src_ptr + (src_rd ? 1 : 0)) >= kill_at));
  end

  // ---------------- scoreboard / monitor ----------------
  logic [DATA_W-1:0] pop_q[$];
  int cur_len = 0, beats_cur = 0;
  int n_done = 0, n_err = 0, n_acc = 0;
  int low_run = 0, last_gap = -1;
  bit prev_req = 1'b0;

  always @(negedge clock) begin
    #1;
    if (reset) begin
      pop_q.delete();
      beats_cur = 0;
      low_run   = 0;
      prev_req  = 1'b0;
    end else begin
      // Every popped word must appear on the bus exactly one cycle later.
      check("bus_valid", 32'(bus_valid), 32'(pop_q.size() != 0));
      if (bus_valid && pop_q.size() != 0) begin
        check("bus_data", 32'(bus_data), 32'(pop_q.pop_front()));
        beats_cur++;
        check("done_on_last", 32'(done), 32'(beats_cur == cur_len + 1));
      end else begin
        check("done_no_beat", 32'(done), 0);
      end
      if (src_rd) pop_q.push_back(src_data);
      if (done) begin
        n_done++;
        beats_cur = 0;
      end
      if (err) begin
        check("err_short", 32'(beats_cur < cur_len + 1), 1);
        n_err++;
        beats_cur = 0;
      end
      if (cmd_valid && cmd_ready) begin
        check("accept_idle", 32'(busy), 0);
        cur_len   = int'(cmd_len);
        beats_cur = 0;
        n_acc++;
      end
      if (req) begin
        if (!prev_req) last_gap = low_run;
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_req = req;
    end
  end

  // ---------------- burst driver ----------------
  // Issues one command from IDLE and measures, in cycles after the accept edge,
  // the first pop, the done/err pulse, and the wait until cmd_ready returns.
  task automatic do_burst(input int len, output bit got_done, output bit got_err,
                          output int t_rd, output int t_end, output int t_idle,
                          output int pops, output logic [DATA_W-1:0] last_data);
    int p0;
    int t;
    p0        = src_ptr;
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    @(negedge clock);
    cmd_valid = 1'b0;
    check("req_after_accept", 32'(req), 1);
    check("ready_low_busy", 32'(cmd_ready), 0);
    t = 1; t_rd = 0; t_end = 0; got_done = 1'b0; got_err = 1'b0; last_data = '0;
    while (t_end == 0 && t < 300) begin
      if (src_rd && t_rd == 0) t_rd = t;
      if (done || err) begin
        t_end     = t;
        got_done  = done;
        got_err   = err;
        last_data = bus_data;
      end else begin
        @(negedge clock);
        t++;
      end
    end
    check("burst_ends", 32'(t_end != 0), 1);
    check("req_low_at_end", 32'(req), 0);
    t_idle = 0;
    while (!cmd_ready && t_idle < 50) begin
      @(negedge clock);
      t_idle++;
    end
    pops = src_ptr - p0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit gd, ge;
    int trd, tend, tidle, pops, len, t, a0, d0, e0, p0;
    logic [DATA_W-1:0] ld;

    for (int i = 0; i < 256; i++) src_mem[i] = DATA_W'($urandom);

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_req", 32'(req), 0);
    check("rst_src_rd", 32'(src_rd), 0);
    check("rst_bus_valid", 32'(bus_valid), 0);
    check("rst_bus_data", 32'(bus_data), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    @(negedge clock);

    // Burst of 4 with known words A0..A3
    for (int i = 0; i < 4; i++) src_mem[(src_ptr + i) & 255] = 8'hA0 + 8'(i);
    do_burst(3, gd, ge, trd, tend, tidle, pops, ld);
    check("b4_first_rd", 32'(trd), 3);
    check("b4_done_cycle", 32'(tend), 7);
    check("b4_done", 32'(gd), 1);
    check("b4_no_err", 32'(ge), 0);
    check("b4_last_data", 32'(ld), 32'h0A3);
    check("b4_pops", 32'(pops), 4);
    check("b4_idle_wait", 32'(tidle), 2);
    check("b4_err_code", 32'(err_code), 0);

    // Single-beat and maximum-length bursts
    do_burst(0, gd, ge, trd, tend, tidle, pops, ld);
    check("b1_first_rd", 32'(trd), 3);
    check("b1_done_cycle", 32'(tend), 4);
    check("b1_done", 32'(gd), 1);
    check("b1_pops", 32'(pops), 1);
    do_burst(15, gd, ge, trd, tend, tidle, pops, ld);
    check("b16_done_cycle", 32'(tend), 19);
    check("b16_done", 32'(gd), 1);
    check("b16_pops", 32'(pops), 16);

    // Random lengths
    repeat (6) begin
      len = int'($urandom_range(0, 15));
      do_burst(len, gd, ge, trd, tend, tidle, pops, ld);
      check("rnd_done", 32'(gd), 1);
      check("rnd_done_cycle", 32'(tend), 32'(len + 4));
      check("rnd_pops", 32'(pops), 32'(len + 1));
    end

    // Grant withdrawn after two beats of an 8-beat burst
    limit_en = 1'b1;
    kill_at  = src_ptr + 2;
    do_burst(7, gd, ge, trd, tend, tidle, pops, ld);
    limit_en = 1'b0;
    check("lost_err", 32'(ge), 1);
    check("lost_no_done", 32'(gd), 0);
    check("lost_pops", 32'(pops), 2);
    check("lost_err_cycle", 32'(tend), 6);
    check("lost_idle_wait", 32'(tidle), 1);
    check("lost_err_pulse", 32'(err), 0);
    check("lost_err_code", 32'(err_code), 1);

    // Grant never arrives
    arb_on    = 1'b0;
    cmd_valid = 1'b1;
    cmd_len   = 4'd2;
    @(negedge clock);
    cmd_valid = 1'b0;
    t = 1;
`ifdef REQ_TIMEOUT_EN
    while (!err && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("tmo_cycle", 32'(t), 32'(TIMEOUT + 1));
    check("tmo_code", 32'(err_code), 2);
    check("tmo_req_low", 32'(req), 0);
    @(negedge clock);
    check("tmo_back_idle", 32'(cmd_ready), 1);
`else
    e0 = n_err;
    repeat (100) @(negedge clock);
    check("wait_req_held", 32'(req), 1);
    check("wait_busy", 32'(busy), 1);
    check("wait_no_err", 32'(n_err - e0), 0);
    check("wait_code_kept", 32'(err_code), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
`endif
    arb_on = 1'b1;
    @(negedge clock);

    // Reset after the first beat of a 6-beat burst
    cmd_valid = 1'b1;
    cmd_len   = 4'd5;
    @(negedge clock);
    cmd_valid = 1'b0;
    t = 0;
    while (!bus_valid && t < 20) begin
      @(negedge clock);
      t++;
    end
    check("mid_first_beat", 32'(bus_valid), 1);
    d0 = n_done;
    e0 = n_err;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_req", 32'(req), 0);
    check("mid_bus_valid", 32'(bus_valid), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_cmd_ready", 32'(cmd_ready), 1);
    check("mid_done", 32'(done), 0);
    check("mid_err", 32'(err), 0);
    check("mid_err_code", 32'(err_code), 0);
    repeat (5) @(negedge clock);
    check("mid_no_done_after", 32'(n_done - d0), 0);
    check("mid_no_err_after", 32'(n_err - e0), 0);

    // cmd_valid held across two bursts
    a0 = n_acc;
    d0 = n_done;
    p0 = src_ptr;
    cmd_valid = 1'b1;
    cmd_len   = 4'd2;
    t = 0;
    while (n_acc < a0 + 2 && t < 100) begin
      @(negedge clock);
      t++;
    end
    cmd_valid = 1'b0;
    while (n_done < d0 + 2 && t < 200) begin
      @(negedge clock);
      t++;
    end
    check("held_accepts", 32'(n_acc - a0), 2);
    check("held_dones", 32'(n_done - d0), 2);
    check("held_req_gap", 32'(last_gap), 3);
    check("held_pops", 32'(src_ptr - p0), 6);
    repeat (4) @(negedge clock);
    check("held_no_third", 32'(n_acc - a0), 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
